// File: rtl/flopoco_fmt_pkg.sv
// FloPoCo 11_52 word format: exception codes, field widths and bit positions
// shared by the IEEE-754 binary64 encoder and any later decoder/check bench.
package flopoco_fmt_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int IEEE_W = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'd2047;

  // IEEE binary64 field positions
  localparam int IEEE_FRAC_LSB = 0;
  localparam int IEEE_EXP_LSB  = FRAC_W;
  localparam int IEEE_SIGN_BIT = EXP_W + FRAC_W;

  // FloPoCo word field positions: {exn[1:0], sign, exp, frac}
  localparam int FPC_FRAC_LSB = 0;
  localparam int FPC_FRAC_MSB = FRAC_W - 1;
  localparam int FPC_EXP_LSB  = FRAC_W;
  localparam int FPC_EXP_MSB  = FRAC_W + EXP_W - 1;
  localparam int FPC_SIGN_BIT = FRAC_W + EXP_W;
  localparam int FPC_EXN_LSB  = FRAC_W + EXP_W + 1;
  localparam int FPC_EXN_MSB  = FRAC_W + EXP_W + 2;

  typedef enum logic [1:0] {
    FPC_EXN_ZERO = 2'b00,
    FPC_EXN_NORM = 2'b01,
    FPC_EXN_INF  = 2'b10,
    FPC_EXN_NAN  = 2'b11
  } fpc_exn_e;

  typedef struct packed {
    fpc_exn_e            exn;
    logic                sign;
    logic [EXP_W-1:0]    exp;
    logic [FRAC_W-1:0]   frac;
  } fpc_word_t;

  function automatic logic is_subnormal(input logic [IEEE_W-1:0] w);
    return (w[IEEE_EXP_LSB +: EXP_W] == '0) && (w[IEEE_FRAC_LSB +: FRAC_W] != '0);
  endfunction

endpackage

// File: rtl/flopoco_classify_11_52.sv
// Combinational IEEE binary64 -> FloPoCo 11_52 packer. Subnormals flush to zero;
// non-normal classes carry only sign and exception code.
module flopoco_classify_11_52
  import flopoco_fmt_pkg::*;
(
  input  logic [IEEE_W-1:0] ieee_i,
  output fpc_word_t         word_o
);

  logic              sign_f;
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              exp_zero;
  logic              exp_max;
  logic              frac_zero;
  fpc_exn_e          exn;

  assign sign_f    = ieee_i[IEEE_SIGN_BIT];
  assign exp_f     = ieee_i[IEEE_EXP_LSB +: EXP_W];
  assign frac_f    = ieee_i[IEEE_FRAC_LSB +: FRAC_W];
  assign exp_zero  = (exp_f == '0);
  assign exp_max   = (exp_f == EXP_MAX);
  assign frac_zero = (frac_f == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    exn = FPC_EXN_NORM;
    if (exp_zero) begin
      exn = FPC_EXN_ZERO;
    end else if (exp_max) begin
      exn = frac_zero ? FPC_EXN_INF : FPC_EXN_NAN;
    end

    word_o      = '0;
    word_o.exn  = exn;
    word_o.sign = sign_f;
    if (exn == FPC_EXN_NORM) begin
      word_o.exp  = exp_f;
      word_o.frac = frac_f;
    end
  end

endmodule

// File: rtl/ieee754_to_flopoco_11_52.sv
// Two-stage stallable IEEE binary64 -> FloPoCo 11_52 encoder with valid/ready on both sides.
// Optional FPC_SUBNORM_COUNT_EN adds a saturating count of flushed subnormal inputs.
module ieee754_to_flopoco_11_52 #(
  parameter int width  = 65,
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width:0]          out_data
`ifdef FPC_SUBNORM_COUNT_EN
  ,output logic [15:0]            subnorm_cnt
`endif
);

  import flopoco_fmt_pkg::*;

  fpc_word_t cls_word;

  logic      s1_v_q, s1_v_d;
  fpc_word_t s1_word_q, s1_word_d;
  logic      s2_v_q, s2_v_d;
  fpc_word_t s2_word_q, s2_word_d;

  logic      s1_fire;
  logic      in_fire;

  flopoco_classify_11_52 u_classify (
    .ieee_i (in_data),
    .word_o (cls_word)
  );

  // S1 may move only into an empty S2 or one whose word leaves on this edge.
  assign s1_fire  = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = rst && (!s1_v_q || s1_fire);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_word_d = s1_word_q;
    if (in_fire) begin
      s1_v_d    = 1'b1;
      s1_word_d = cls_word;
    end else if (s1_fire) begin
      s1_v_d = 1'b0;
    end

    s2_v_d    = s2_v_q;
    s2_word_d = s2_word_q;
    if (s1_fire) begin
      s2_v_d    = 1'b1;
      s2_word_d = s1_word_q;
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments; data registers are reset
  // too so out_data reads zero after reset rather than a stale word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_word_q <= '0;
      s2_v_q    <= 1'b0;
      s2_word_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_word_q <= s1_word_d;
      s2_v_q    <= s2_v_d;
      s2_word_q <= s2_word_d;
    end
  end

  assign out_valid = s2_v_q;

  always_comb begin
    out_data = '0;
    out_data[FPC_EXN_MSB:FPC_EXN_LSB]   = s2_word_q.exn;
    out_data[FPC_SIGN_BIT]              = s2_word_q.sign;
    out_data[FPC_EXP_MSB:FPC_EXP_LSB]   = s2_word_q.exp;
    out_data[FPC_FRAC_MSB:FPC_FRAC_LSB] = s2_word_q.frac;
  end

`ifdef FPC_SUBNORM_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counted at acceptance, not at output, so stalled words are counted once.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && is_subnormal(in_data) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign subnorm_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ieee754_to_flopoco_11_52.sv
// Self-checking bench: directed literal cases, backpressure, streaming, random
// handshakes and async reset, all compared against a queue-based reference encoder.
module tb_ieee754_to_flopoco_11_52;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data   = '0;
  logic        in_ready;
  logic        out_valid;
  logic [65:0] out_data;
`ifdef FPC_SUBNORM_COUNT_EN
  logic [15:0] subnorm_cnt;
  int unsigned exp_cnt = 0;
`endif

  ieee754_to_flopoco_11_52 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FPC_SUBNORM_COUNT_EN
    ,.subnorm_cnt (subnorm_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [65:0] word;
    int          c;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  ent_t q[$];
  ent_t mon[$];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [65:0] ref_enc(input logic [63:0] d);
    logic        s;
    logic [10:0] e;
    logic [51:0] f;
    s = d[63];
    e = d[62:52];
    f = d[51:0];
    if (e == 11'd0)    return {2'b00, s, 63'd0};
    if (e == 11'h7FF)  return {(f == 52'd0) ? 2'b10 : 2'b11, s, 63'd0};
    return {2'b01, d};
  endfunction

  // Word in flight for >= 2 cycles at the head of the queue must be on the output.
  function automatic logic exp_valid();
    if (q.size() == 0) return 1'b0;
    return cyc >= q[0].c + 2;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] r;
    logic [10:0] e;
    int          k;
    r = {$urandom(), $urandom()};
    k = $urandom_range(0, 5);
    case (k)
      0:       begin e = 11'd0;   r[51:0] = '0; end
      1:       begin e = 11'd0;   if (r[51:0] == '0) r[0] = 1'b1; end
      2:       begin e = 11'h7FF; r[51:0] = '0; end
      3:       begin e = 11'h7FF; if (r[51:0] == '0) r[51] = 1'b1; end
      default: e = 11'($urandom_range(1, 2046));
    endcase
    r[62:52] = e;
    return r;
  endfunction

  // Reference model: in-order queue of accepted words, updated on each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
`ifdef FPC_SUBNORM_COUNT_EN
      exp_cnt = 0;
`endif
    end else begin
      logic acc;
      logic hv;
      hv  = exp_valid();
      acc = in_valid && ((q.size() < 2) || out_ready);
      if (hv && out_ready) void'(q.pop_front());
      if (acc) begin
        q.push_back('{ref_enc(in_data), cyc});
`ifdef FPC_SUBNORM_COUNT_EN
        if (in_data[62:52] == 11'd0 && in_data[51:0] != 52'd0 && exp_cnt != 32'hFFFF)
          exp_cnt = exp_cnt + 1;
`endif
      end
      cyc++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_in_ready", in_ready, 66'd0);
      check("rst_out_valid", out_valid, 66'd0);
      check("rst_out_data", out_data, 66'd0);
    end else begin
      logic hv;
      hv = exp_valid();
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("out_valid", out_valid, hv);
      if (hv) check("out_data", out_data, q[0].word);
      if (out_valid && out_ready) mon.push_back('{out_data, cyc});
    end
`ifdef FPC_SUBNORM_COUNT_EN
    check("subnorm_cnt", subnorm_cnt, exp_cnt);
`endif
  end

  task automatic pin(input string name, input logic [63:0] d, input logic [65:0] req);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({name, "_valid"}, out_valid, 66'd1);
    check({name, "_data"}, out_data, req);
  endtask

  logic [63:0] bp_in[3]  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000};
  logic [65:0] bp_out[3] = '{{2'b01, 1'b0, 11'h3FF, 52'h0},
                             {2'b01, 1'b0, 11'h400, 52'h0},
                             {2'b01, 1'b0, 11'h400, 52'h8000000000000}};

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    pin("one",      64'h3FF0000000000000, {2'b01, 1'b0, 11'h3FF, 52'h0});
    pin("neg_zero", 64'h8000000000000000, {2'b00, 1'b1, 63'd0});
    pin("pos_inf",  64'h7FF0000000000000, {2'b10, 1'b0, 63'd0});
    pin("neg_nan",  64'hFFF8000000000000, {2'b11, 1'b1, 63'd0});
    pin("subnorm",  64'h0000000000000001, 66'd0);
    pin("max_norm", 64'h7FEFFFFFFFFFFFFF, {2'b01, 64'h7FEFFFFFFFFFFFFF});
`ifdef FPC_SUBNORM_COUNT_EN
    check("subnorm_cnt_one", subnorm_cnt, 66'd1);
`endif

    // Backpressure: only two words fit while the sink is stalled.
    begin
      int   idx;
      logic acc;
      idx = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
        in_valid = 1'b1;
        in_data  = bp_in[idx];
        @(negedge clk) acc = in_ready;
        @(posedge clk); #1;
        if (acc) idx++;
        if (idx == 3) break;
      end
      check("bp_accepts", idx, 66'd2);
      check("bp_full_in_ready", in_ready, 66'd0);
      mon.delete();
      out_ready = 1'b1;
      for (int k = 0; k < 6 && in_valid; k++) begin
        @(negedge clk) acc = in_ready;
        @(posedge clk); #1;
        if (acc) in_valid = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      check("bp_count", mon.size(), 66'd3);
      if (mon.size() == 3) begin
        for (int i = 0; i < 3; i++) check($sformatf("bp_order_%0d", i), mon[i].word, bp_out[i]);
        check("bp_no_gap", mon[2].c - mon[0].c, 66'd2);
      end
    end

    // Streaming: 100 words back-to-back with the sink always ready.
    mon.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = rand_word();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_count", mon.size(), 66'd100);
    if (mon.size() == 100) check("stream_no_gap", mon[99].c - mon[0].c, 66'd99);

    // Random valid/ready on both sides.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_word();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Async reset with two words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h3FF0000000000000;
    @(posedge clk); #1;
    in_data   = 64'h4000000000000000;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", out_valid, 66'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 66'd0);
    check("rst_async_in_ready", in_ready, 66'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    mon.delete();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_output", mon.size(), 66'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
